// File: rtl/regfile_pkg.sv
// Shared types and constants for the 32 x 64-bit architectural register file.
// Also holds the 5:32 one-hot write-enable decoder used by the write port.
package regfile_pkg;

  localparam int DATA_W   = 64;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 32;
  localparam logic [ADDR_W-1:0] ZERO_REG = 5'd31;

  typedef logic [ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0] reg_data_t;

  function automatic logic [NUM_REGS-1:0] decode_5to32(input reg_addr_t addr, input logic en);
    logic [NUM_REGS-1:0] onehot;
    onehot       = {NUM_REGS{1'b0}};
    onehot[addr] = en;
    return onehot;
  endfunction

endpackage

// File: rtl/regfile_if.sv
// Decode-stage register-file bus: the write-back write port plus two read ports.
interface regfile_if;
  import regfile_pkg::*;

  logic      RegWrite;
  reg_addr_t WriteRegister;
  reg_data_t WriteData;
  reg_addr_t ReadRegister1;
  reg_addr_t ReadRegister2;
  reg_data_t ReadData1;
  reg_data_t ReadData2;

  modport master (
    output RegWrite, WriteRegister, WriteData, ReadRegister1, ReadRegister2,
    input  ReadData1, ReadData2
  );

  modport slave (
    input  RegWrite, WriteRegister, WriteData, ReadRegister1, ReadRegister2,
    output ReadData1, ReadData2
  );
endinterface

// File: rtl/regfile_reg64.sv
// One DATA_W-wide storage register with load enable and async active-high clear.
module reg64
  import regfile_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      en,
  input  reg_data_t d,
  output reg_data_t q
);

  reg_data_t data_q;
  reg_data_t data_d;

  always_comb begin
    data_d = data_q;
    if (en) begin
      data_d = d;
    end else begin
      data_d = data_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= {DATA_W{1'b0}};
    end else begin
      data_q <= data_d;
    end
  end

  assign q = data_q;

endmodule

// File: rtl/regfile.sv
// Architectural register file X0-X31 (X31 reads as zero) with two combinational
// read ports and a same-cycle write-through bypass from the write-back stage.
module regfile
  import regfile_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  regfile_if.slave  rf
);

  logic [NUM_REGS-1:0] dec_s;
  logic                unused_dec31_s;
  reg_data_t           regs_s [NUM_REGS];
  logic                bypass1_s;
  logic                bypass2_s;
  reg_data_t           rd1_s;
  reg_data_t           rd2_s;

  // X31 has no storage, so its decoded enable goes nowhere.
  assign dec_s          = decode_5to32(rf.WriteRegister, rf.RegWrite & ~reset);
  assign unused_dec31_s = dec_s[NUM_REGS-1];
  assign regs_s[NUM_REGS-1] = {DATA_W{1'b0}};

  for (genvar g = 0; g < NUM_REGS - 1; g++) begin : g_regs
    reg64 u_reg (
      .clk (clk),
      .rst (reset),
      .en  (dec_s[g]),
      .d   (rf.WriteData),
      .q   (regs_s[g])
    );
  end

  assign bypass1_s = rf.RegWrite & ~reset & (rf.WriteRegister == rf.ReadRegister1);
  assign bypass2_s = rf.RegWrite & ~reset & (rf.WriteRegister == rf.ReadRegister2);

  // Bypass mux sits after the 32:1 storage mux; a write to X31 never bypasses.
  always_comb begin
    rd1_s = {DATA_W{1'b0}};
    if (rf.ReadRegister1 == ZERO_REG) begin
      rd1_s = {DATA_W{1'b0}};
    end else if (bypass1_s) begin
      rd1_s = rf.WriteData;
    end else begin
      rd1_s = regs_s[rf.ReadRegister1];
    end
  end

  always_comb begin
    rd2_s = {DATA_W{1'b0}};
    if (rf.ReadRegister2 == ZERO_REG) begin
      rd2_s = {DATA_W{1'b0}};
    end else if (bypass2_s) begin
      rd2_s = rf.WriteData;
    end else begin
      rd2_s = regs_s[rf.ReadRegister2];
    end
  end

  assign rf.ReadData1 = rd1_s;
  assign rf.ReadData2 = rd2_s;

endmodule

// File: doc/regfile.md
# regfile

Architectural integer register file for the pipelined ARM CPU: 32 × 64-bit registers addressed X0–X31, with X31 hardwired to zero. It sits in the decode stage. Two combinational read ports feed the ID/EX latch. One clocked write port is driven by the write-back stage. The write port's per-register enables come from a 5:32 write-enable decoder gated by `RegWrite`. A same-cycle write-through bypass removes the WB→ID hazard.

## Interface
- `DATA_W`, 64, register width in bits
- `ADDR_W`, 5, register address width; register count is 2^ADDR_W = 32
- `clk`  in  1  system clock; all writes occur on its rising edge
- `reset`  in  1  asynchronous, active-high; clears all registers
- `RegWrite`  in  1  write request from WB stage
- `WriteRegister`  in  ADDR_W  destination register index
- `WriteData`  in  DATA_W  value to write
- `ReadRegister1`  in  ADDR_W  read port 1 index
- `ReadRegister2`  in  ADDR_W  read port 2 index
- `ReadData1`  out  DATA_W  read port 1 data, combinational
- `ReadData2`  out  DATA_W  read port 2 data, combinational

## Operation
- Storage is 31 physical 64-bit registers, X0–X30. X31 has no storage.
- Write enables: one-hot decode of `WriteRegister`, ANDed with `RegWrite` and with `!reset`. Enable bit 31 is discarded.
- Write: on a rising `clk` with `RegWrite`=1 and `WriteRegister`≠31, register[`WriteRegister`] takes `WriteData`. All other registers hold.
- Write to X31 is a no-op. It does not fault and has no side effects.
- Read port N behaviour, with each port evaluated independently:
  - If `ReadRegisterN`=31, the port returns 0.
  - Otherwise, if `RegWrite`=1, `WriteRegister`=`ReadRegisterN` and `reset`=0, the port returns `WriteData` (bypass).
  - Otherwise, the port returns register[`ReadRegisterN`].
- Both ports may address the same register. Both then return identical data, including under bypass.
- Reset: asserting `reset` immediately clears X0–X30 to 0, with no clock edge needed.
  - While `reset` is high, writes are suppressed and bypass is disabled, so both outputs read 0 for every address.
- Reset mid-operation: a write coinciding with a `clk` edge while `reset` is high is lost.
  - On `reset` deassertion, the first write can occur at the next rising `clk`.

## Timing
- Read latency is 0 cycles: outputs are a pure combinational function of the addresses, `RegWrite`, `WriteRegister`, `WriteData`, `reset` and the register state.
- Write latency is 1 edge. The value is visible through storage from the cycle after the edge, and through the bypass during the write cycle itself.
- Output reset values: `ReadData1` = `ReadData2` = 0 while `reset` is high.
- Bypass path: address compare plus a 2:1 mux after the 32:1 read mux. It must meet the decode-stage combinational budget.
- Writes are not negedge-timed. The bypass replaces the half-cycle write trick.

## Structure
- Shared package `regfile_pkg` holds:
  - `DATA_W` = 64, `ADDR_W` = 5, `NUM_REGS` = 32, `ZERO_REG` = 5'd31
  - typedef `reg_addr_t` = logic [4:0]
  - typedef `reg_data_t` = logic [63:0]
- Sub-module `reg64`: a DATA_W-wide register with enable and async active-high reset to 0. It is instantiated 31 times via `generate`.
- The write-enable decode reuses the existing 5:32 decoder. Its enable is `RegWrite & ~reset`.
- The read path uses a 32:1 mux per port, with input 31 tied to 0.

## Test plan
- Reset clear: write 64'hDEAD_BEEF to X5, then pulse `reset` between clock edges. Reading X5 returns 0 immediately, before any `clk` edge.
- Basic write/read:
  - Write 64'h0123_4567_89AB_CDEF to X0 and 64'hFFFF_FFFF_FFFF_FFFF to X30 on consecutive cycles.
  - Port 1 on X0 and port 2 on X30 return those values next cycle. X1–X29 remain 0.
- Zero register: write 64'h1234 to X31 with `RegWrite`=1. Both ports on X31 return 0, during the write cycle and afterwards.
- Bypass:
  - Set `RegWrite`=1, `WriteRegister`=7, `WriteData`=64'hAA55, and both read addresses to 7. Both ports show 64'hAA55 in the same cycle, before the edge.
  - Change `WriteData` to 64'h55AA after the edge with `RegWrite`=0. Both ports still read 64'hAA55.
- Write gating: `RegWrite`=0 with `WriteRegister`=3 and `WriteData`=64'h77 across 3 edges leaves X3 = 0 and bypass inactive.
- Reset during write: assert `reset` across a `clk` edge with `RegWrite`=1, `WriteRegister`=9, `WriteData`=64'h99. After deassertion X9 reads 0, and the next write of 64'h99 succeeds on the following edge.
